// File: rtl/lsm_pkg.sv
// Shared constants for the load/store-multiple decode sequencer.
package lsm_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int BASE_HI = 11;
  localparam int BASE_LO = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

endpackage

// File: rtl/lsm_sequencer_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot and any-set flag.
module lsb_prio_enc #(
  parameter int NREG = 8,
  parameter int RA_W = 3
) (
  input  logic [NREG-1:0] mask_i,
  output logic [RA_W-1:0] idx_o,
  output logic [NREG-1:0] onehot_o,
  output logic            any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = mask_i & (~mask_i + NREG'(1));
  assign any_o    = |mask_i;

  always_comb begin
    idx_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = RA_W'(i);
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Decode-stage LM/SM micro-sequencer; passes other instructions through.
// Build option LSM_EMPTY_SKIP_EN drops LM/SM with an empty register mask.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_ir,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_ir,
  output logic [DATA_W-1:0] out_pc,
  output logic              out_uop,
  output logic              out_is_lm,
  output logic              out_is_sm,
  output logic [RA_W-1:0]   out_reg,
  output logic [RA_W-1:0]   out_base,
  output logic [DATA_W-1:0] out_offset,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  state_e state_q, state_d;
  logic [NREG-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              uop_q, uop_d;
  logic              lm_q, lm_d;
  logic              sm_q, sm_d;
  logic [RA_W-1:0]   reg_q, reg_d;
  logic [RA_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0] off_q, off_d;
  logic              first_q, first_d;
  logic              last_q, last_d;

  logic [NREG-1:0] enc_in, enc_oh, rem_nxt;
  logic [RA_W-1:0] enc_idx;
  logic            enc_any;
  logic [3:0]      opc;
  logic            is_lsm, accept, drop;

  assign opc    = in_ir[OPC_HI:OPC_LO];
  assign is_lsm = (opc == OP_LM) | (opc == OP_SM);
  assign enc_in = (state_q == ST_SEQ) ? rem_q : in_ir[NREG-1:0];

  lsb_prio_enc #(
    .NREG (NREG),
    .RA_W (RA_W)
  ) u_enc (
    .mask_i   (enc_in),
    .idx_o    (enc_idx),
    .onehot_o (enc_oh),
    .any_o    (enc_any)
  );

  assign rem_nxt = enc_in & ~enc_oh;

  assign in_ready = rst_n & (state_q == ST_IDLE)
                  & (~vld_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

`ifdef LSM_EMPTY_SKIP_EN
  assign drop = is_lsm & ~enc_any;
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    uop_d   = uop_q;
    lm_d    = lm_q;
    sm_d    = sm_q;
    reg_d   = reg_q;
    base_d  = base_q;
    off_d   = off_q;
    first_d = first_q;
    last_d  = last_q;
    if (flush) begin
      vld_d   = 1'b0;
      rem_d   = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      if (vld_q && out_ready) vld_d = 1'b0;
      if (accept && !drop) begin
        vld_d   = 1'b1;
        ir_d    = in_ir;
        pc_d    = in_pc;
        base_d  = in_ir[BASE_HI:BASE_LO];
        reg_d   = '0;
        off_d   = '0;
        first_d = 1'b1;
        last_d  = 1'b1;
        uop_d   = 1'b0;
        lm_d    = 1'b0;
        sm_d    = 1'b0;
        if (is_lsm && enc_any) begin
          uop_d  = 1'b1;
          lm_d   = (opc == OP_LM);
          sm_d   = (opc == OP_SM);
          reg_d  = enc_idx;
          rem_d  = rem_nxt;
          cnt_d  = DATA_W'(1);
          last_d = ~|rem_nxt;
          if (|rem_nxt) state_d = ST_SEQ;
        end
      end else if (state_q == ST_SEQ && out_ready) begin
        vld_d   = 1'b1;
        reg_d   = enc_idx;
        off_d   = cnt_q;
        first_d = 1'b0;
        rem_d   = rem_nxt;
        cnt_d   = cnt_q + DATA_W'(1);
        last_d  = ~|rem_nxt;
        if (~|rem_nxt) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
      uop_q   <= 1'b0;
      lm_q    <= 1'b0;
      sm_q    <= 1'b0;
      reg_q   <= '0;
      base_q  <= '0;
      off_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      uop_q   <= uop_d;
      lm_q    <= lm_d;
      sm_q    <= sm_d;
      reg_q   <= reg_d;
      base_q  <= base_d;
      off_q   <= off_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_ir     = ir_q;
  assign out_pc     = pc_q;
  assign out_uop    = uop_q;
  assign out_is_lm  = lm_q;
  assign out_is_sm  = sm_q;
  assign out_reg    = reg_q;
  assign out_base   = base_q;
  assign out_offset = off_q;
  assign out_first  = first_q;
  assign out_last   = last_q;
  assign busy       = (state_q == ST_SEQ);

endmodule

// File: tb/tb_lsm_sequencer.sv
// Randomized self-checking bench for lsm_sequencer against a beat-queue model.
module tb_lsm_sequencer;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [15:0] in_ir, in_pc;
  logic        out_valid, out_ready;
  logic [15:0] out_ir, out_pc, out_offset;
  logic        out_uop, out_is_lm, out_is_sm;
  logic [2:0]  out_reg, out_base;
  logic        out_first, out_last, busy;

  lsm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ir      (in_ir),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ir     (out_ir),
    .out_pc     (out_pc),
    .out_uop    (out_uop),
    .out_is_lm  (out_is_lm),
    .out_is_sm  (out_is_sm),
    .out_reg    (out_reg),
    .out_base   (out_base),
    .out_offset (out_offset),
    .out_first  (out_first),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic        uop, lm, sm;
    logic [2:0]  rg, base;
    logic [15:0] off;
    logic        first, last;
  } beat_t;

  beat_t q[$];
  int    errs, checks;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(beat_t b);
    return {5'b0, b.ir, b.pc, b.uop, b.lm, b.sm, b.rg, b.base,
            b.off, b.first, b.last};
  endfunction

  function automatic logic [63:0] dut_beat();
    return {5'b0, out_ir, out_pc, out_uop, out_is_lm, out_is_sm,
            out_reg, out_base, out_offset, out_first, out_last};
  endfunction

  // Expected beats of one accepted instruction, from the opcode/mask rules.
  function automatic void push_expected(logic [15:0] ir, logic [15:0] pc);
    beat_t b;
    int n = 0;
    int k = 0;
    logic [7:0] m = ir[7:0];
    logic [3:0] op = ir[15:12];
    b = '{ir: ir, pc: pc, uop: 1'b0, lm: 1'b0, sm: 1'b0, rg: 3'd0,
          base: ir[11:9], off: 16'd0, first: 1'b1, last: 1'b1};
    if (op == 4'h6 || op == 4'h7) begin
      for (int i = 0; i < 8; i++) n += int'(m[i]);
      if (n == 0) begin
`ifndef LSM_EMPTY_SKIP_EN
        q.push_back(b);
`endif
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (m[i]) begin
            b.uop   = 1'b1;
            b.lm    = (op == 4'h6);
            b.sm    = (op == 4'h7);
            b.rg    = 3'(i);
            b.off   = 16'(k);
            b.first = (k == 0);
            b.last  = (k == n - 1);
            q.push_back(b);
            k++;
          end
        end
      end
    end else begin
      q.push_back(b);
    end
  endfunction

  task automatic step(input logic v, input logic [15:0] ir,
                      input logic [15:0] pc, input logic rdy,
                      input logic fl);
    logic  exp_rdy;
    beat_t b;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = v;
    in_ir = ir;
    in_pc = pc;
    out_ready = rdy;
    flush = fl;
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (out_valid && q.size() > 0) chk("beat", dut_beat(), pack(q[0]));
    chk("busy", 64'(busy), 64'(q.size() > 1));
    exp_rdy = !fl && (q.size() == 0 || (q.size() == 1 && rdy));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid && rdy && q.size() > 0) b = q.pop_front();
    if (fl) q.delete();
    else if (v && in_ready) push_expected(ir, pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_ctrl", 64'({out_valid, busy, in_ready}), 64'd0);
    chk("rst_data", dut_beat(), 64'd0);
    q.delete();
  endtask

  function automatic logic [15:0] rand_ir();
    logic [15:0] ir;
    int r = int'($urandom_range(0, 9));
    logic [15:0] tbl[4] = '{16'h0298, 16'h64A5, 16'h7E81, 16'h6000};
    ir = 16'($urandom);
    if (r < 4) begin
      ir[15:12] = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'h7;
      if ($urandom_range(0, 7) == 0) ir[7:0] = 8'h00;
    end else if (r < 5) begin
      ir = tbl[$urandom_range(0, 3)];
    end else begin
      while (ir[15:12] == 4'h6 || ir[15:12] == 4'h7) ir[15:12] = 4'($urandom);
    end
    return ir;
  endfunction

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ir = '0;
    in_pc = '0;
    out_ready = 1'b0;
    errs = 0;
    checks = 0;

    do_reset();
    step(1'b1, 16'h0298, 16'h0100, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 16'h64A5, 16'h0102, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 16'h7E81, 16'h0104, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 16'h6000, 16'h0106, 1'b1, 1'b0);
    step(1'b1, 16'h0298, 16'h0108, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 16'h64A5, 16'h010A, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    step(1'b1, 16'h0298, 16'h010C, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 16'h64A5, 16'h010E, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    do_reset();
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) < 7, rand_ir(), 16'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      if (i % 1000 == 999) do_reset();
    end

    idle(12);
    chk("drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
